// File: rtl/term_fifo_bank.sv
// Bank of independent first-word-fall-through FIFOs, one per mesh terminal channel.
// Each channel reports occupancy flags, head broadcast status and a saturating drop count.

module term_fifo_chan #(
  parameter int          pckg_sz    = 40,
  parameter int          fifo_depth = 4,
  parameter logic [7:0]  bdcst      = {8{1'b1}},
  parameter int          AF_LEVEL   = fifo_depth - 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               push,
  input  logic [pckg_sz-1:0] data_in,
  input  logic               pop,
  output logic [pckg_sz-1:0] data_out,
  output logic               pndng,
  output logic               full,
  output logic               almost_full,
  output logic               bdcst_hd,
  output logic [7:0]         drop_cnt
);

  localparam int CW = $clog2(fifo_depth + 1);
  localparam int PW = (fifo_depth > 1) ? $clog2(fifo_depth) : 1;

  logic [pckg_sz-1:0] mem_q [fifo_depth];
  logic [pckg_sz-1:0] mem_d [fifo_depth];
  logic [PW-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [7:0]         drop_q, drop_d;

  logic               do_push, do_pop, do_drop;
  logic [pckg_sz-1:0] head;

  // Status flags come only from the registered occupancy, never from push/pop.
  always_comb begin
    pndng       = (cnt_q != '0);
    full        = (cnt_q == CW'(fifo_depth));
    almost_full = (cnt_q >= CW'(AF_LEVEL));
    head        = mem_q[rd_ptr_q];
    data_out    = pndng ? head : '0;
    bdcst_hd    = pndng && (head[pckg_sz-9 -: 8] == bdcst);
    drop_cnt    = drop_q;
  end

  // A pop while full frees the slot the same-cycle push lands in.
  always_comb begin
    do_pop  = pop && pndng;
    do_push = push && (!full || pop);
    do_drop = push && full && !pop;
  end

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned, which would infer a latch.
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    drop_d   = drop_q;

    if (do_push) begin
      mem_d[wr_ptr_q] = data_in;
      wr_ptr_d = (wr_ptr_q == PW'(fifo_depth - 1)) ? '0 : wr_ptr_q + PW'(1);
    end

    if (do_pop) begin
      rd_ptr_d = (rd_ptr_q == PW'(fifo_depth - 1)) ? '0 : rd_ptr_q + PW'(1);
    end

    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase

    if (do_drop && (drop_q != 8'hFF)) begin
      drop_d = drop_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      drop_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      drop_q   <= drop_d;
    end
  end

  // NOTE: storage is left out of reset; a zero occupancy already hides stale entries and keeps this a plain RAM.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

module term_fifo_bank #(
  parameter int          CHANNELS   = 16,
  parameter int          pckg_sz    = 40,
  parameter int          fifo_depth = 4,
  parameter logic [7:0]  bdcst      = {8{1'b1}},
  parameter int          AF_LEVEL   = fifo_depth - 1
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [CHANNELS-1:0]         push,
  input  logic [CHANNELS*pckg_sz-1:0] data_in,
  input  logic [CHANNELS-1:0]         pop,
  output logic [CHANNELS*pckg_sz-1:0] data_out,
  output logic [CHANNELS-1:0]         pndng,
  output logic [CHANNELS-1:0]         full,
  output logic [CHANNELS-1:0]         almost_full,
  output logic [CHANNELS-1:0]         bdcst_hd,
  output logic [CHANNELS*8-1:0]       drop_cnt
);

  for (genvar c = 0; c < CHANNELS; c++) begin : g_chan
    term_fifo_chan #(
      .pckg_sz    (pckg_sz),
      .fifo_depth (fifo_depth),
      .bdcst      (bdcst),
      .AF_LEVEL   (AF_LEVEL)
    ) u_chan (
      .clk         (clk),
      .reset       (reset),
      .push        (push[c]),
      .data_in     (data_in[c*pckg_sz +: pckg_sz]),
      .pop         (pop[c]),
      .data_out    (data_out[c*pckg_sz +: pckg_sz]),
      .pndng       (pndng[c]),
      .full        (full[c]),
      .almost_full (almost_full[c]),
      .bdcst_hd    (bdcst_hd[c]),
      .drop_cnt    (drop_cnt[c*8 +: 8])
    );
  end

endmodule

// File: tb/tb_term_fifo_bank.sv
// Self-checking bench for term_fifo_bank: a vector table on one channel, directed corner sequences,
// and random traffic, all compared every cycle against a queue-based model of each channel.

module tb_term_fifo_bank;

  localparam int CH = 16;
  localparam int PW = 40;
  localparam int D  = 4;
  localparam int DW = CH * PW;

  logic                clk = 1'b0;
  logic                reset;
  logic [CH-1:0]       push, pop;
  logic [DW-1:0]       data_in;
  logic [DW-1:0]       data_out;
  logic [CH-1:0]       pndng, full, almost_full, bdcst_hd;
  logic [CH*8-1:0]     drop_cnt;

  int errors = 0;
  int checks = 0;

  logic [PW-1:0] mq [CH][$];
  int unsigned   md [CH];

  typedef struct {
    logic          push;
    logic          pop;
    logic [PW-1:0] data;
    logic          e_pndng;
    logic          e_full;
    logic          e_af;
    logic [7:0]    e_drop;
    logic [PW-1:0] e_dout;
  } vec_t;

  vec_t tbl [12];

  always #5 clk = ~clk;

  term_fifo_bank #(
    .CHANNELS   (CH),
    .pckg_sz    (PW),
    .fifo_depth (D)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .push        (push),
    .data_in     (data_in),
    .pop         (pop),
    .data_out    (data_out),
    .pndng       (pndng),
    .full        (full),
    .almost_full (almost_full),
    .bdcst_hd    (bdcst_hd),
    .drop_cnt    (drop_cnt)
  );

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic clr_in();
    push    = '0;
    pop     = '0;
    data_in = '0;
  endtask

  // Channel behaviour from the rules: queue of at most D packets, drops counted when full without pop.
  task automatic model_edge();
    for (int c = 0; c < CH; c++) begin
      if (!reset) begin
        mq[c].delete();
        md[c] = 0;
      end else begin
        int n;
        bit was_full;
        n = mq[c].size();
        was_full = (n == D);
        if (pop[c] && n > 0) void'(mq[c].pop_front());
        if (push[c]) begin
          if (!was_full || pop[c]) mq[c].push_back(data_in[c*PW +: PW]);
          else if (md[c] < 255) md[c]++;
        end
      end
    end
  endtask

  task automatic compare_all();
    logic [CH-1:0]   ep, ef, ea, eb;
    logic [DW-1:0]   ed;
    logic [CH*8-1:0] edc;
    logic [PW-1:0]   hd;
    ep = '0; ef = '0; ea = '0; eb = '0; ed = '0; edc = '0;
    for (int c = 0; c < CH; c++) begin
      int n;
      n = mq[c].size();
      ep[c] = (n > 0);
      ef[c] = (n == D);
      ea[c] = (n >= D - 1);
      hd = (n > 0) ? mq[c][0] : '0;
      ed[c*PW +: PW] = hd;
      eb[c] = (n > 0) && (hd[31:24] == 8'hFF);
      edc[c*8 +: 8] = 8'(md[c]);
    end
    check("pndng",       DW'(pndng),       DW'(ep));
    check("full",        DW'(full),        DW'(ef));
    check("almost_full", DW'(almost_full), DW'(ea));
    check("bdcst_hd",    DW'(bdcst_hd),    DW'(eb));
    check("data_out",    data_out,         ed);
    check("drop_cnt",    DW'(drop_cnt),    DW'(edc));
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    compare_all();
  endtask

  task automatic push_ch(input int c, input logic [PW-1:0] d);
    clr_in();
    push[c] = 1'b1;
    data_in[c*PW +: PW] = d;
    tick();
  endtask

  initial begin
    logic [63:0] r;

    tbl[0]  = '{1'b1, 1'b0, 40'h00_23_0_00000, 1'b1, 1'b0, 1'b0, 8'd0, 40'h00_23_0_00000};
    tbl[1]  = '{1'b1, 1'b0, 40'h00_23_0_00001, 1'b1, 1'b0, 1'b0, 8'd0, 40'h00_23_0_00000};
    tbl[2]  = '{1'b1, 1'b0, 40'h00_23_0_00002, 1'b1, 1'b0, 1'b1, 8'd0, 40'h00_23_0_00000};
    tbl[3]  = '{1'b1, 1'b0, 40'h00_23_0_00003, 1'b1, 1'b1, 1'b1, 8'd0, 40'h00_23_0_00000};
    tbl[4]  = '{1'b1, 1'b0, 40'h00_23_0_00004, 1'b1, 1'b1, 1'b1, 8'd1, 40'h00_23_0_00000};
    tbl[5]  = '{1'b1, 1'b0, 40'h00_23_0_00005, 1'b1, 1'b1, 1'b1, 8'd2, 40'h00_23_0_00000};
    tbl[6]  = '{1'b1, 1'b0, 40'h00_23_0_00006, 1'b1, 1'b1, 1'b1, 8'd3, 40'h00_23_0_00000};
    tbl[7]  = '{1'b0, 1'b1, 40'h0,             1'b1, 1'b0, 1'b1, 8'd3, 40'h00_23_0_00001};
    tbl[8]  = '{1'b0, 1'b1, 40'h0,             1'b1, 1'b0, 1'b0, 8'd3, 40'h00_23_0_00002};
    tbl[9]  = '{1'b0, 1'b1, 40'h0,             1'b1, 1'b0, 1'b0, 8'd3, 40'h00_23_0_00003};
    tbl[10] = '{1'b0, 1'b1, 40'h0,             1'b0, 1'b0, 1'b0, 8'd3, 40'h0};
    tbl[11] = '{1'b0, 1'b1, 40'h0,             1'b0, 1'b0, 1'b0, 8'd3, 40'h0};

    clr_in();
    reset = 1'b0;
    tick();
    push = '1;
    data_in = {CH{40'hAB_CD_E_12345}};
    tick();
    clr_in();
    check("rst_pndng", DW'(pndng), '0);
    check("rst_dout",  data_out,   '0);
    check("rst_drop",  DW'(drop_cnt), '0);
    reset = 1'b1;

    // Single packet on ch0, visible next cycle, not a broadcast.
    push_ch(0, 40'h00_20_8_00001);
    check("c0_pndng", DW'(pndng), DW'(16'h0001));
    check("c0_dout",  DW'(data_out[PW-1:0]), DW'(40'h00_20_8_00001));
    check("c0_bdcst", DW'(bdcst_hd[0]), DW'(1'b0));
    clr_in();
    pop[0] = 1'b1;
    tick();

    // Vector table on ch3: fill, overflow, drain, underflow.
    for (int i = 0; i < 12; i++) begin
      clr_in();
      push[3] = tbl[i].push;
      pop[3]  = tbl[i].pop;
      data_in[3*PW +: PW] = tbl[i].data;
      tick();
      check($sformatf("tbl%0d_pndng", i), DW'(pndng[3]),          DW'(tbl[i].e_pndng));
      check($sformatf("tbl%0d_full", i),  DW'(full[3]),           DW'(tbl[i].e_full));
      check($sformatf("tbl%0d_af", i),    DW'(almost_full[3]),    DW'(tbl[i].e_af));
      check($sformatf("tbl%0d_drop", i),  DW'(drop_cnt[24 +: 8]), DW'(tbl[i].e_drop));
      check($sformatf("tbl%0d_dout", i),  DW'(data_out[3*PW +: PW]), DW'(tbl[i].e_dout));
    end

    // Drop counter saturation on ch5.
    for (int i = 0; i < D + 300; i++) push_ch(5, 40'h01_11_0_00000 + 40'(i));
    check("sat_drop5", DW'(drop_cnt[40 +: 8]), DW'(8'd255));
    check("sat_full5", DW'(full[5]), DW'(1'b1));

    // ch7 full with simultaneous push and pop, pointers wrap.
    for (int i = 0; i < D; i++) push_ch(7, 40'h02_33_0_00000 + 40'(i));
    for (int i = 0; i < 10; i++) begin
      clr_in();
      push[7] = 1'b1;
      pop[7]  = 1'b1;
      data_in[7*PW +: PW] = 40'h02_33_0_00100 + 40'(i);
      tick();
      check($sformatf("wrap%0d_full", i), DW'(full[7]), DW'(1'b1));
      check($sformatf("wrap%0d_drop", i), DW'(drop_cnt[56 +: 8]), '0);
    end
    check("wrap_head", DW'(data_out[7*PW +: PW]), DW'(40'h02_33_0_00106));

    // Broadcast head on ch9; pop on empty ch10.
    push_ch(9, 40'h05_FF_1_0ABCD);
    check("bc9", DW'(bdcst_hd[9]), DW'(1'b1));
    clr_in();
    pop[10] = 1'b1;
    tick();
    check("pop_empty10", DW'({pndng[10], drop_cnt[80 +: 8]}), '0);

    // Empty channel with push and pop together: push wins, no bypass.
    clr_in();
    push[12] = 1'b1;
    pop[12]  = 1'b1;
    data_in[12*PW +: PW] = 40'h07_12_0_00777;
    tick();
    check("pp_empty12", DW'(data_out[12*PW +: PW]), DW'(40'h07_12_0_00777));

    // Mid-operation reset with push on ch1.
    push_ch(1, 40'h03_44_0_00001);
    push_ch(1, 40'h03_44_0_00002);
    clr_in();
    reset = 1'b0;
    push[1] = 1'b1;
    data_in[1*PW +: PW] = 40'h03_44_0_00003;
    tick();
    check("mrst_pndng1", DW'(pndng[1]), '0);
    check("mrst_dout1",  DW'(data_out[1*PW +: PW]), '0);
    check("mrst_drop5",  DW'(drop_cnt[40 +: 8]), '0);
    reset = 1'b1;
    push_ch(1, 40'h03_44_0_00004);
    check("mrst_next1", DW'(data_out[1*PW +: PW]), DW'(40'h03_44_0_00004));

    // Random traffic in push-heavy and pop-heavy phases with rare resets.
    for (int i = 0; i < 600; i++) begin
      if ((i / 100) % 2 == 0) begin
        push = CH'($urandom() | $urandom());
        pop  = CH'($urandom() & $urandom());
      end else begin
        push = CH'($urandom() & $urandom());
        pop  = CH'($urandom() | $urandom());
      end
      for (int c = 0; c < CH; c++) begin
        r = {$urandom(), $urandom()};
        if (r[63:60] == 4'h0) r[31:24] = 8'hFF;
        data_in[c*PW +: PW] = r[PW-1:0];
      end
      reset = ($urandom_range(149) != 0);
      tick();
    end
    reset = 1'b1;
    clr_in();
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
